alu_muldiv_sequencer: RTL and testbench
=======================================

# alu_muldiv_sequencer

Multi-cycle sequencer that computes unsigned multiply (low word), unsigned divide and unsigned remainder by driving the core's shared ALU for one add or subtract per clock. It sits beside the ALU in the execute stage. While idle it does not use the ALU. When running, it owns the ALU's operand and control inputs and reads back the ALU result. A start/busy/done handshake stalls the pipeline until the result is ready.

## Interface
- BUS_WIDTH, 32, operand/result width; a power of two, at least 4
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  request; accepted only in IDLE
- i_op  in  2  00 MUL (low word), 01 DIVU, 10 REMU, 11 reserved
- i_operand_a  in  BUS_WIDTH  multiplicand / dividend
- i_operand_b  in  BUS_WIDTH  multiplier / divisor
- o_alu_src_a  out  BUS_WIDTH  to ALU i_SrcA
- o_alu_src_b  out  BUS_WIDTH  to ALU i_SrcB
- o_alu_control  out  3  to ALU i_AluControl (000 ADD, 001 SUB only)
- i_alu_result  in  BUS_WIDTH  from ALU o_Result
- o_busy  out  1  high from the cycle after accept through the DONE cycle
- o_done  out  1  one-cycle pulse, result valid
- o_result  out  BUS_WIDTH  registered result, held until the next accept
- o_div_by_zero  out  1  set with o_done when DIVU/REMU has divisor 0; held with o_result

## Operation
- States are IDLE, RUN and DONE. The step counter is clog2(BUS_WIDTH) bits wide.
- IDLE with i_start=1 is an accept:
  - Latch the op and operands. Clear the counter.
  - DIVU/REMU with i_operand_b=0: go to DONE. Result is all-ones for DIVU and i_operand_a for REMU. Set o_div_by_zero=1.
  - Op 11: go to DONE with result 0 and o_div_by_zero=0.
  - Otherwise go to RUN.
- MUL (shift-add). Registers are acc=0, mcand=a, mplier=b.
  - Each RUN cycle, drive ALU srcA=acc, srcB=mcand, control=000.
  - If mplier[0]=1, load acc from i_alu_result.
  - Then shift mcand left by 1 and mplier right by 1.
  - Result is acc, i.e. the product modulo 2^BUS_WIDTH.
- DIVU/REMU (restoring). Registers are rem=0, quot=a, div=b.
  - Each RUN cycle, form carry=rem[MSB] and partial={rem[BUS_WIDTH-2:0], quot[MSB]}.
  - Drive ALU srcA=partial, srcB=div, control=001.
  - Subtraction succeeds when carry is 1, or when partial is greater than or equal to div (unsigned).
  - This comparison uses the block's own comparator. The ALU's set-less-than is not used.
  - On success, rem is loaded from i_alu_result. Otherwise rem is loaded from partial.
  - quot is loaded from {quot[BUS_WIDTH-2:0], success}.
  - DIVU returns quot. REMU returns rem.
- RUN advances the counter every cycle. In the cycle where the counter equals BUS_WIDTH-1, the last step is done and the state goes to DONE.
- DONE: o_done=1 and o_result is updated. Next state is IDLE.
- Outside RUN, the ALU drive outputs are 0/0/000.

## Timing
- Reset state, taken when i_rst_n is low at a rising edge:
  - State IDLE.
  - o_busy, o_done, o_div_by_zero, o_result and all internal registers are 0.
  - ALU drive outputs are 0.
- Normal op, with accept at edge T:
  - RUN covers cycles T+1 through T+BUS_WIDTH.
  - DONE is cycle T+BUS_WIDTH+1, with o_done high.
  - IDLE returns at T+BUS_WIDTH+2, where a new accept is allowed.
  - Latency is BUS_WIDTH+1 cycles from accept to o_done.
- Fast path (divisor 0 or op 11): DONE is cycle T+1, and IDLE returns at T+2.
- o_result and o_div_by_zero are written as they enter DONE. They stay stable until the next DONE.
- i_start while o_busy=1 (RUN or DONE) is ignored, with no queueing.
- Changes to operands or op after accept have no effect.
- Reset low during RUN or DONE: the next cycle is IDLE with every output at its reset value. No o_done is produced.
- Back-to-back: an i_start held high continuously gets accepted again in the first IDLE cycle after DONE.
- The ALU is combinational. i_alu_result is sampled on the same edge that ends each RUN cycle, so there is no extra ALU latency.

## Test plan
- MUL 7×6:
  - Accept at T -> o_busy is high T+1..T+33; o_done at T+33 with o_result=42.
  - ALU control is 000 every RUN cycle.
- MUL 0xFFFFFFFF×0xFFFFFFFF -> o_result=0x00000001. MUL 0x80000000×2 -> 0x00000000.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. o_div_by_zero=0 for both; o_done at T+33.
- DIVU 0xFFFFFFFF/0x80000001 -> 1 and REMU -> 0x7FFFFFFE; this exercises the carry path.
- Divide by zero and reserved op:
  - DIVU 5/0 -> o_done at T+1, o_result=0xFFFFFFFF, o_div_by_zero=1.
  - REMU 5/0 -> 5. Op 11 -> o_result=0 at T+1.
- Ignored start and mid-run reset:
  - Pulse i_start at T+5 during a MUL -> ignored, and the original result is unchanged.
  - Drop i_rst_n at T+10 -> o_busy=0 and o_result=0 at T+11, and no o_done appears.
  - A fresh DIVU 9/3 accepted afterwards returns 3.

Source files
------------

// File: rtl/alu_muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_muldiv_sequencer_if
//
// Bundle of the request/response handshake and the shared-ALU drive/readback
// signals of alu_muldiv_sequencer.
//
//   slave  modport : the sequencer itself
//   master modport : the execute stage / ALU side
//
// Signals (BUS_WIDTH = operand/result width):
//   i_start        request, accepted only while the sequencer is idle
//   i_op           00 MUL (low word), 01 DIVU, 10 REMU, 11 reserved
//   i_operand_a    multiplicand / dividend
//   i_operand_b    multiplier / divisor
//   o_alu_src_a    ALU operand A drive
//   o_alu_src_b    ALU operand B drive
//   o_alu_control  ALU operation (000 ADD, 001 SUB)
//   i_alu_result   combinational ALU result
//   o_busy         high from the cycle after accept through the done cycle
//   o_done         one-cycle pulse, result valid
//   o_result       registered result
//   o_div_by_zero  divisor was zero for DIVU/REMU
// ---------------------------------------------------------------------------
interface alu_muldiv_sequencer_if #(
  parameter int BUS_WIDTH = 32
) ();

  logic                 i_start;
  logic [1:0]           i_op;
  logic [BUS_WIDTH-1:0] i_operand_a;
  logic [BUS_WIDTH-1:0] i_operand_b;
  logic [BUS_WIDTH-1:0] o_alu_src_a;
  logic [BUS_WIDTH-1:0] o_alu_src_b;
  logic [2:0]           o_alu_control;
  logic [BUS_WIDTH-1:0] i_alu_result;
  logic                 o_busy;
  logic                 o_done;
  logic [BUS_WIDTH-1:0] o_result;
  logic                 o_div_by_zero;

  modport slave (
    input  i_start,
    input  i_op,
    input  i_operand_a,
    input  i_operand_b,
    input  i_alu_result,
    output o_alu_src_a,
    output o_alu_src_b,
    output o_alu_control,
    output o_busy,
    output o_done,
    output o_result,
    output o_div_by_zero
  );

  modport master (
    output i_start,
    output i_op,
    output i_operand_a,
    output i_operand_b,
    output i_alu_result,
    input  o_alu_src_a,
    input  o_alu_src_b,
    input  o_alu_control,
    input  o_busy,
    input  o_done,
    input  o_result,
    input  o_div_by_zero
  );

endinterface : alu_muldiv_sequencer_if

// File: rtl/alu_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// alu_muldiv_sequencer
//
// Multi-cycle unsigned MUL (low word), DIVU and REMU built on the core's
// shared ALU: one ADD (shift-add multiply) or one SUB (restoring divide) per
// clock, BUS_WIDTH steps per operation. Idle -> ALU drive is all zeros.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   bus      alu_muldiv_sequencer_if.slave (handshake, operands, ALU drive,
//            result); BUS_WIDTH must match the interface instance.
//
// Timing (accept in cycle T):
//   normal : RUN T+1..T+BUS_WIDTH, DONE T+BUS_WIDTH+1, IDLE T+BUS_WIDTH+2
//   fast   : divisor 0 or reserved op -> DONE T+1, IDLE T+2
// ---------------------------------------------------------------------------
module alu_muldiv_sequencer #(
  parameter int BUS_WIDTH = 32
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  alu_muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(BUS_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BUS_WIDTH - 1);
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Working registers are shared between the two algorithms:
  //   acc_q : MUL accumulator        / DIV partial remainder
  //   sh_q  : MUL shifting multiplicand / DIV dividend-in, quotient-out
  //   opb_q : MUL shifting multiplier   / DIV divisor (static)
  state_e               state_q,  state_d;
  op_e                  op_q,     op_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [BUS_WIDTH-1:0] acc_q,    acc_d;
  logic [BUS_WIDTH-1:0] sh_q,     sh_d;
  logic [BUS_WIDTH-1:0] opb_q,    opb_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;
  logic                 dbz_q,    dbz_d;

  logic [BUS_WIDTH-1:0] alu_src_a;
  logic [BUS_WIDTH-1:0] alu_src_b;
  logic [2:0]           alu_control;

  // Restoring-divide step. The bit shifted out of the remainder (carry)
  // means the true partial is >= 2^BUS_WIDTH, which always exceeds the
  // divisor; the ALU's wrapped difference is then still the correct
  // remainder because it is smaller than the divisor.
  logic                 div_carry;
  logic [BUS_WIDTH-1:0] div_partial;
  logic                 div_ok;

  always_comb begin
    div_carry   = acc_q[BUS_WIDTH-1];
    div_partial = {acc_q[BUS_WIDTH-2:0], sh_q[BUS_WIDTH-1]};
    div_ok      = div_carry | (div_partial >= opb_q);
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    opb_d       = opb_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_control = ALU_ADD;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          op_d  = op_e'(bus.i_op);
          cnt_d = '0;
          acc_d = '0;
          sh_d  = bus.i_operand_a;
          opb_d = bus.i_operand_b;
          unique case (op_e'(bus.i_op))
            OP_DIVU, OP_REMU: begin
              if (bus.i_operand_b == '0) begin
                // Divide by zero resolves immediately: quotient all-ones,
                // remainder equals the dividend.
                state_d  = S_DONE;
                result_d = (op_e'(bus.i_op) == OP_DIVU) ? '1 : bus.i_operand_a;
                dbz_d    = 1'b1;
              end else begin
                state_d = S_RUN;
              end
            end
            OP_RSVD: begin
              state_d  = S_DONE;
              result_d = '0;
              dbz_d    = 1'b0;
            end
            default: begin
              state_d = S_RUN;
            end
          endcase
        end
      end

      S_RUN: begin
        if (op_q == OP_MUL) begin
          alu_src_a   = acc_q;
          alu_src_b   = sh_q;
          alu_control = ALU_ADD;
          if (opb_q[0]) begin
            acc_d = bus.i_alu_result;
          end
          sh_d  = sh_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          alu_src_a   = div_partial;
          alu_src_b   = opb_q;
          alu_control = ALU_SUB;
          acc_d       = div_ok ? bus.i_alu_result : div_partial;
          sh_d        = {sh_q[BUS_WIDTH-2:0], div_ok};
        end

        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Capture from the final step's next values so the result is
          // ready in the DONE cycle without an extra register stage.
          state_d  = S_DONE;
          dbz_d    = 1'b0;
          result_d = (op_q == OP_DIVU) ? sh_d : acc_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register (synchronous reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.o_alu_src_a   = alu_src_a;
    bus.o_alu_src_b   = alu_src_b;
    bus.o_alu_control = alu_control;
    bus.o_busy        = (state_q != S_IDLE);
    bus.o_done        = (state_q == S_DONE);
    bus.o_result      = result_q;
    bus.o_div_by_zero = dbz_q;
  end

endmodule : alu_muldiv_sequencer

// File: tb/tb_alu_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_sequencer
//
// Scoreboard bench: the driver pushes the reference-model answer (result,
// divide-by-zero flag, cycle in which o_done must appear) when it issues a
// request; the monitor pops on o_done and also checks o_busy, held results
// and the ALU drive every cycle. A combinational ADD/SUB ALU model closes
// the loop.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    int           done_cyc;
  } exp_t;

  logic i_clk;
  logic i_rst_n;
  int   cyc;

  alu_muldiv_sequencer_if #(.BUS_WIDTH(W)) bus ();

  alu_muldiv_sequencer #(.BUS_WIDTH(W)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  // Shared ALU: combinational, only ADD and SUB are meaningful here.
  assign bus.i_alu_result = (bus.o_alu_control == 3'b000) ? bus.o_alu_src_a + bus.o_alu_src_b :
                            (bus.o_alu_control == 3'b001) ? bus.o_alu_src_a - bus.o_alu_src_b :
                                                            '0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard and model state shared by driver and monitor.
  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           mon_en   = 1'b0;
  int           t_acc    = -1000;
  int           lat      = 1;
  logic [1:0]   cur_op   = 2'b00;
  logic [W-1:0] held_res = '0;
  logic         held_dbz = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definition.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int t);
    exp_t e;
    int   l;
    e.dbz = 1'b0;
    l     = W + 1;
    case (op)
      2'b00: e.res = a * b;
      2'b01: begin
        if (b == 0) begin e.res = '1; e.dbz = 1'b1; l = 1; end
        else e.res = a / b;
      end
      2'b10: begin
        if (b == 0) begin e.res = a; e.dbz = 1'b1; l = 1; end
        else e.res = a % b;
      end
      default: begin e.res = '0; l = 1; end
    endcase
    e.done_cyc = t + l;
    return e;
  endfunction

  // Record an accept that happens at the end of cycle t.
  task automatic register_accept(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int t);
    exp_t e;
    e = model(op, a, b, t);
    sb_q.push_back(e);
    t_acc  = t;
    lat    = e.done_cyc - t;
    cur_op = op;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge i_clk) begin
    if (mon_en) begin
      automatic bit in_win = (cyc >= t_acc + 1) && (cyc <= t_acc + lat);
      automatic bit in_run = (cyc >= t_acc + 1) && (cyc <= t_acc + lat - 1);
      exp_t e;

      check("busy", {31'b0, bus.o_busy}, {31'b0, in_win});

      if (in_run) begin
        check("alu_ctrl_run", {29'b0, bus.o_alu_control},
              (cur_op == 2'b00) ? 32'd0 : 32'd1);
      end else begin
        check("alu_ctrl_idle", {29'b0, bus.o_alu_control}, 32'd0);
        check("alu_src_a_idle", bus.o_alu_src_a, '0);
        check("alu_src_b_idle", bus.o_alu_src_b, '0);
      end

      if (bus.o_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("result", bus.o_result, e.res);
          check("div_by_zero", {31'b0, bus.o_div_by_zero}, {31'b0, e.dbz});
          held_res = e.res;
          held_dbz = e.dbz;
        end
      end else begin
        if (sb_q.size() != 0 && cyc >= sb_q[0].done_cyc) begin
          check("missing_done", 32'd0, 32'd1);
          e = sb_q.pop_front();
          held_res = e.res;
          held_dbz = e.dbz;
        end
        check("result_held", bus.o_result, held_res);
        check("dbz_held", {31'b0, bus.o_div_by_zero}, {31'b0, held_dbz});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (bus.o_busy && k < 200);
    if (bus.o_busy) check("idle_timeout", 32'd1, 32'd0);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic scramble();
    bus.i_op        = 2'($urandom);
    bus.i_operand_a = $urandom;
    bus.i_operand_b = $urandom;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    register_accept(op, a, b, cyc);
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
    scramble();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    logic [1:0]   op;
    logic [W-1:0] a, b;

    i_rst_n         = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_op        = 2'b00;
    bus.i_operand_a = '0;
    bus.i_operand_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    mon_en = 1'b1;

    // Directed cases.
    issue(2'b00, 32'd7, 32'd6);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'h8000_0000, 32'd2);
    issue(2'b01, 32'd100, 32'd7);
    issue(2'b10, 32'd100, 32'd7);
    issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
    issue(2'b01, 32'd5, 32'd0);
    issue(2'b10, 32'd5, 32'd0);
    issue(2'b11, 32'd123, 32'd4);

    // Start pulse during RUN is ignored.
    issue(2'b00, 32'd1234, 32'd5678);
    t0 = t_acc;
    wait_cyc(t0 + 5);
    bus.i_start     = 1'b1;
    bus.i_op        = 2'b01;
    bus.i_operand_a = 32'd99;
    bus.i_operand_b = 32'd3;
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;

    // Reset in the middle of a run: no done, outputs back to zero.
    issue(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    t0 = t_acc;
    wait_cyc(t0 + 10);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    sb_q.delete();
    t_acc    = -1000;
    lat      = 1;
    held_res = '0;
    held_dbz = 1'b0;
    i_rst_n  = 1'b1;
    issue(2'b01, 32'd9, 32'd3);

    // Back-to-back: start held high is accepted again right after DONE.
    wait_idle();
    bus.i_start     = 1'b1;
    bus.i_op        = 2'b10;
    bus.i_operand_a = 32'd1000;
    bus.i_operand_b = 32'd37;
    t0 = cyc;
    register_accept(2'b10, 32'd1000, 32'd37, t0);
    wait_cyc(t0 + W + 2);
    register_accept(2'b10, 32'd1000, 32'd37, t0 + W + 2);
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
    scramble();

    // Randomized mix, including zero divisors and the reserved op.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = 32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      issue(op, a, b);
    end

    begin
      int k = 0;
      while (sb_q.size() != 0 && k < 200) begin
        @(posedge i_clk);
        k++;
      end
      if (sb_q.size() != 0) check("drain_timeout", 32'd1, 32'd0);
    end
    repeat (3) @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_muldiv_sequencer
